// File: rtl/freq_div_pkg.sv
// Shared types and defaults for the frequency divider and its ratio controller.
package freq_div_pkg;

  localparam int W_DEFAULT             = 4;
  localparam int DEFAULT_RATIO_DEFAULT = 7;
  localparam int RATIO_MIN             = 2;

  typedef enum logic [1:0] {
    LOAD,
    RUN,
    DRAIN,
    HALT
  } state_t;

endpackage

// File: rtl/freq_div_phase_ctr.sv
// Tracks the divider phase while the divider runs and flags the last cycle of each period.
module freq_div_phase_ctr #(
  parameter int W = freq_div_pkg::W_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic [W-1:0] ratio,
  output logic         period_end
);

  logic [W-1:0] phase;

  assign period_end = run && (phase == ratio - 1'b1);

  // Phase restarts from zero whenever the divider is held in reset.
  always_ff @(posedge clk) begin
    if (!reset || !run) begin
      phase <= '0;
    end else if (period_end) begin
      phase <= '0;
    end else begin
      phase <= phase + 1'b1;
    end
  end

endmodule

// File: rtl/freq_div_ratio_ctrl.sv
// Run-time ratio controller: validates change requests and reloads the divider on period boundaries.
module freq_div_ratio_ctrl
  import freq_div_pkg::*;
#(
  parameter int W             = W_DEFAULT,
  parameter int DEFAULT_RATIO = DEFAULT_RATIO_DEFAULT,
  parameter int RST_CYCLES    = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         req_valid,
  input  logic [W-1:0] req_ratio,
  output logic         req_ready,
  output logic [W-1:0] div_mc,
  output logic         div_rst,
  output logic [W-1:0] cur_ratio,
  output logic         period_end,
  output logic         busy,
  output logic         done,
  output logic         err
);

  localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_LAST = CW'(RST_CYCLES - 1);
  localparam logic [W-1:0]  DEF_RATIO = W'(DEFAULT_RATIO);
  localparam logic [W-1:0]  MIN_RATIO = W'(RATIO_MIN);

  state_t        state;
  logic [W-1:0]  pend;
  logic [CW-1:0] load_cnt;
  logic          from_req;
  logic          run;
  logic          accept;

  // The divider keeps counting during DRAIN, so the boundary is tracked there too.
  assign run       = (state == RUN) || (state == DRAIN);
  assign req_ready = (state == RUN) && en && reset;
  assign accept    = req_valid && req_ready;

  freq_div_phase_ctr #(.W(W)) u_phase (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .ratio      (cur_ratio),
    .period_end (period_end)
  );

  // div_mc is only rewritten on entry to LOAD, while div_rst is already high.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= LOAD;
      cur_ratio <= DEF_RATIO;
      div_mc    <= DEF_RATIO - 1'b1;
      div_rst   <= 1'b1;
      busy      <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
      pend      <= '0;
      load_cnt  <= '0;
      from_req  <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (!en) begin
        state    <= HALT;
        div_rst  <= 1'b1;
        busy     <= 1'b1;
        pend     <= '0;
        load_cnt <= '0;
        from_req <= 1'b0;
      end else begin
        case (state)
          LOAD: begin
            if (load_cnt == LOAD_LAST) begin
              state    <= RUN;
              div_rst  <= 1'b0;
              busy     <= 1'b0;
              done     <= from_req;
              from_req <= 1'b0;
              load_cnt <= '0;
            end else begin
              load_cnt <= load_cnt + 1'b1;
            end
          end
          RUN: begin
            if (accept) begin
              if (req_ratio < MIN_RATIO) begin
                err <= 1'b1;
              end else if (req_ratio == cur_ratio) begin
                done <= 1'b1;
              end else begin
                pend  <= req_ratio;
                state <= DRAIN;
                busy  <= 1'b1;
              end
            end
          end
          DRAIN: begin
            if (period_end) begin
              cur_ratio <= pend;
              div_mc    <= pend - 1'b1;
              div_rst   <= 1'b1;
              state     <= LOAD;
              from_req  <= 1'b1;
              load_cnt  <= '0;
            end
          end
          HALT: begin
            state    <= LOAD;
            div_mc   <= cur_ratio - 1'b1;
            load_cnt <= '0;
            from_req <= 1'b0;
          end
          default: state <= HALT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_freq_div_ratio_ctrl.sv
// Directed bench for freq_div_ratio_ctrl with a done/err pulse scoreboard.
module tb_freq_div_ratio_ctrl;

  typedef struct {
    bit         is_done;
    logic [3:0] ratio;
    int         due;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       req_valid;
  logic [3:0] req_ratio;
  logic       req_ready;
  logic [3:0] div_mc;
  logic       div_rst;
  logic [3:0] cur_ratio;
  logic       period_end;
  logic       busy;
  logic       done;
  logic       err;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  exp_t sb[$];
  exp_t mon_e;

  freq_div_ratio_ctrl #(.W(4), .DEFAULT_RATIO(7), .RST_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .req_valid  (req_valid),
    .req_ratio  (req_ratio),
    .req_ready  (req_ready),
    .div_mc     (div_mc),
    .div_rst    (div_rst),
    .cur_ratio  (cur_ratio),
    .period_end (period_end),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic v, input logic [3:0] r);
    req_valid = v;
    req_ratio = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every done/err pulse must match the oldest expected event, including its cycle.
  always @(negedge clk) begin
    if (done || err) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("[TB] FAIL unexpected_pulse at cycle %0d: got done=%0d err=%0d expected none",
                 cyc, done, err);
      end else begin
        mon_e = sb.pop_front();
        if ((mon_e.is_done ? !(done && !err) : !(err && !done)) ||
            cur_ratio !== mon_e.ratio || cyc != mon_e.due) begin
          failures++;
          $display("[TB] FAIL pulse_event: got done=%0d err=%0d ratio=%0d cycle=%0d expected done=%0d err=%0d ratio=%0d cycle=%0d",
                   done, err, cur_ratio, cyc, mon_e.is_done, !mon_e.is_done,
                   mon_e.ratio, mon_e.due);
        end
      end
    end
  end

  initial begin
    reset = 1'b0;
    en    = 1'b1;
    apply_stimulus(1'b0, 4'd0);

    tick();
    check_output("rst_div_rst", div_rst, 1);
    check_output("rst_div_mc", div_mc, 6);
    check_output("rst_cur_ratio", cur_ratio, 7);
    check_output("rst_busy", busy, 1);
    check_output("rst_req_ready", req_ready, 0);
    check_output("rst_done", done, 0);
    check_output("rst_err", err, 0);
    check_output("rst_period_end", period_end, 0);
    reset = 1'b1;
    tick();
    check_output("load2_div_rst", div_rst, 1);
    check_output("load2_req_ready", req_ready, 0);
    tick();
    check_output("run_div_rst", div_rst, 0);
    check_output("run_busy", busy, 0);
    check_output("run_req_ready", req_ready, 1);
    repeat (5) tick();
    check_output("pe_before", period_end, 0);
    tick();
    check_output("pe_first", period_end, 1);
    repeat (7) tick();
    check_output("pe_period7", period_end, 1);

    // Illegal ratio 1
    sb.push_back('{1'b0, 4'd7, 17});
    apply_stimulus(1'b1, 4'd1);
    tick();
    apply_stimulus(1'b0, 4'd0);
    check_output("err_cur_ratio", cur_ratio, 7);
    check_output("err_div_rst", div_rst, 0);
    check_output("err_busy", busy, 0);
    tick();

    // Same ratio request
    sb.push_back('{1'b1, 4'd7, 19});
    apply_stimulus(1'b1, 4'd7);
    tick();
    apply_stimulus(1'b0, 4'd0);
    check_output("same_div_rst", div_rst, 0);
    check_output("same_cur_ratio", cur_ratio, 7);
    repeat (4) tick();
    check_output("same_pe", period_end, 1);
    check_output("same_div_rst2", div_rst, 0);

    // Ratio 3 presented at phase 2
    repeat (3) tick();
    sb.push_back('{1'b1, 4'd3, 33});
    apply_stimulus(1'b1, 4'd3);
    tick();
    apply_stimulus(1'b0, 4'd0);
    check_output("drain_busy", busy, 1);
    check_output("drain_req_ready", req_ready, 0);
    check_output("drain_div_mc", div_mc, 6);
    repeat (3) tick();
    check_output("drain_pe", period_end, 1);
    check_output("drain_cur_ratio", cur_ratio, 7);
    check_output("drain_div_rst", div_rst, 0);
    tick();
    check_output("reload_div_rst", div_rst, 1);
    check_output("reload_div_mc", div_mc, 2);
    check_output("reload_cur_ratio", cur_ratio, 3);
    tick();
    check_output("reload_div_rst2", div_rst, 1);
    tick();
    check_output("r3_div_rst", div_rst, 0);
    check_output("r3_busy", busy, 0);
    repeat (2) tick();
    check_output("r3_pe1", period_end, 1);
    tick();
    check_output("r3_pe_gap", period_end, 0);
    repeat (2) tick();
    check_output("r3_pe2", period_end, 1);

    // Ratio 5 accepted on a boundary, then en dropped at the next boundary
    apply_stimulus(1'b1, 4'd5);
    tick();
    apply_stimulus(1'b0, 4'd0);
    check_output("bnd_busy", busy, 1);
    check_output("bnd_req_ready", req_ready, 0);
    check_output("bnd_cur_ratio", cur_ratio, 3);
    repeat (2) tick();
    check_output("bnd_pe_next", period_end, 1);
    check_output("bnd_cur_ratio2", cur_ratio, 3);
    check_output("bnd_div_rst", div_rst, 0);
    en = 1'b0;
    tick();
    check_output("halt_div_rst", div_rst, 1);
    check_output("halt_busy", busy, 1);
    check_output("halt_cur_ratio", cur_ratio, 3);
    check_output("halt_req_ready", req_ready, 0);
    check_output("halt_pe", period_end, 0);
    repeat (2) tick();
    en = 1'b1;
    tick();
    check_output("unhalt_div_rst", div_rst, 1);
    check_output("unhalt_div_mc", div_mc, 2);
    repeat (2) tick();
    check_output("unhalt_run_div_rst", div_rst, 0);
    check_output("unhalt_busy", busy, 0);
    check_output("unhalt_cur_ratio", cur_ratio, 3);

    // Reset during DRAIN with pending ratio 4
    apply_stimulus(1'b1, 4'd4);
    tick();
    apply_stimulus(1'b0, 4'd0);
    check_output("pend4_busy", busy, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check_output("mid_rst_cur_ratio", cur_ratio, 7);
    check_output("mid_rst_div_mc", div_mc, 6);
    check_output("mid_rst_div_rst", div_rst, 1);
    check_output("mid_rst_busy", busy, 1);
    repeat (2) tick();
    check_output("post_rst_div_rst", div_rst, 0);
    check_output("post_rst_busy", busy, 0);
    repeat (6) tick();
    check_output("post_rst_pe", period_end, 1);
    check_output("post_rst_cur_ratio", cur_ratio, 7);
    tick();
    check_output("post_pe_cur_ratio", cur_ratio, 7);
    check_output("post_pe_div_rst", div_rst, 0);
    check_output("post_pe_div_mc", div_mc, 6);
    repeat (6) tick();
    check_output("post_rst_pe2", period_end, 1);

    repeat (2) tick();
    check_output("sb_outstanding", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
